// File: rtl/dot_matrix_scanner.sv
// Row-multiplexed 8x8 LED scanner with a double-buffered frame input and per-row PWM.
// Frames land in a shadow buffer and are promoted to the display buffer only at the row-0 boundary.
module dot_matrix_scanner #(
  parameter int ROW_DWELL    = 6250,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [63:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [2:0]  brightness,
  output logic [7:0]  row,
  output logic [7:0]  col,
  output logic [2:0]  row_idx,
  output logic        frame_done
);
  localparam int DW = $clog2(ROW_DWELL + 1);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state, state_n;
  logic [DW-1:0] dwell_cnt, dwell_n, on_time;
  logic [BW-1:0] blank_cnt, blank_n;
  logic [2:0]    idx, idx_n;
  logic [63:0]   display, shadow;
  logic          pending;
  logic          accept, swap, enter_drive, last_drive;

  // Handshake: a frame transfers on any edge where frame_valid and frame_ready are both high.
  assign accept = frame_valid && frame_ready;

  always_comb begin
    state_n     = state;
    blank_n     = blank_cnt;
    dwell_n     = dwell_cnt;
    idx_n       = idx;
    enter_drive = 1'b0;
    last_drive  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      blank_n = '0;
      dwell_n = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          blank_n = '0;
          idx_n   = '0;
        end
        BLANK: begin
          if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
            state_n     = DRIVE;
            dwell_n     = '0;
            enter_drive = 1'b1;
          end else begin
            blank_n = blank_cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (dwell_cnt == DW'(ROW_DWELL - 1)) begin
            state_n    = BLANK;
            blank_n    = '0;
            idx_n      = idx + 3'd1;
            last_drive = (idx == 3'd7);
          end else begin
            dwell_n = dwell_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Promotion happens only at the row-0 boundary (or while parked in IDLE), so a frame never tears.
  assign swap = pending && ((state == IDLE) || last_drive);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      blank_cnt   <= '0;
      dwell_cnt   <= '0;
      idx         <= '0;
      on_time     <= '0;
      display     <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_ready <= 1'b1;
      row         <= 8'hFF;
      col         <= 8'h00;
      row_idx     <= 3'd0;
      frame_done  <= 1'b0;
    end else begin
      state     <= state_n;
      blank_cnt <= blank_n;
      dwell_cnt <= dwell_n;
      idx       <= idx_n;
      if (enter_drive)
        on_time <= DW'((int'(brightness) + 1) * (ROW_DWELL / 8));
      if (accept) begin
        shadow      <= frame_in;
        pending     <= 1'b1;
        frame_ready <= 1'b0;
      end else if (swap) begin
        display     <= shadow;
        pending     <= 1'b0;
        frame_ready <= 1'b1;
      end
      // Pins follow the scan state one cycle later; dropping enable darkens them immediately.
      row        <= (enable && state == DRIVE) ? 8'(~(8'h01 << idx)) : 8'hFF;
      col        <= (enable && state == DRIVE && dwell_cnt < on_time) ?
                    display[8*(7-idx) +: 8] : 8'h00;
      row_idx    <= enable ? idx : 3'd0;
      frame_done <= last_drive;
    end
  end
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Directed bench for dot_matrix_scanner with ROW_DWELL=16, BLANK_CYCLES=2 (144-cycle frame).
module tb_dot_matrix_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [63:0] frame_in = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [2:0]  brightness = 3'd7;
  logic [7:0]  row, col;
  logic [2:0]  row_idx;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] FRAME_A = 64'h8142241818244281;
  localparam logic [63:0] FRAME_B = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] FRAME_C = 64'h5555555555555555;

  dot_matrix_scanner #(.ROW_DWELL(16), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_in(frame_in),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .brightness(brightness),
    .row(row), .col(col), .row_idx(row_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [63:0] f, input int r);
    logic [63:0] v;
    v = f;
    return v[63-8*r -: 8];
  endfunction

  // Positioned at the first driven cycle of row r; leaves at the first driven cycle of row r+1.
  task automatic scan_row(input int r, input logic [7:0] b, input int on,
                          input int redge, input logic rb, input logic ra);
    logic [7:0] er;
    er = 8'(~(8'h01 << r));
    for (int c = 0; c < 16; c++) begin
      chk("row", row, er);
      chk("col", col, (c < on) ? b : 8'h00);
      chk("row_idx", row_idx, r);
      chk("frame_done", frame_done, (r == 7 && c == 15));
      chk("frame_ready", frame_ready, (c < redge) ? rb : ra);
      tick();
      frame_valid = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      chk("blank_row", row, 8'hFF);
      chk("blank_col", col, 8'h00);
      chk("blank_done", frame_done, 1'b0);
      chk("blank_ready", frame_ready, ra);
      tick();
    end
  endtask

  initial begin
    logic seen;
    // reset with enable held high
    tick(); tick();
    chk("rst_row", row, 8'hFF);
    chk("rst_col", col, 8'h00);
    chk("rst_ready", frame_ready, 1'b1);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_idx", row_idx, 3'd0);

    // load frame A while idle: accept edge, then swap edge
    rst_n = 1'b1; enable = 1'b0;
    frame_in = FRAME_A; frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("accept_ready", frame_ready, 1'b0);
    tick();
    chk("idle_swap_ready", frame_ready, 1'b1);
    chk("idle_row", row, 8'hFF);

    // start scan: row 0 appears 3 edges after enable is sampled
    enable = 1'b1;
    tick(); chk("start_row_e0", row, 8'hFF);
    tick(); chk("start_row_e1", row, 8'hFF);
    tick(); chk("start_row_e2", row, 8'hFF);
    tick();
    for (int r = 0; r < 8; r++) scan_row(r, byte_of(FRAME_A, r), 16, 0, 1'b1, 1'b1);

    // frame 2: offer B during row 3, a stray frame C during row 4
    for (int r = 0; r < 3; r++) scan_row(r, byte_of(FRAME_A, r), 16, 0, 1'b1, 1'b1);
    frame_in = FRAME_B; frame_valid = 1'b1;
    scan_row(3, byte_of(FRAME_A, 3), 16, 1, 1'b1, 1'b0);
    frame_in = FRAME_C; frame_valid = 1'b1;
    for (int r = 4; r < 7; r++) scan_row(r, byte_of(FRAME_A, r), 16, 0, 1'b0, 1'b0);
    scan_row(7, byte_of(FRAME_A, 7), 16, 15, 1'b0, 1'b1);

    // frame 3 shows B; brightness 3 takes effect from row 1, brightness 0 from next row 0
    brightness = 3'd3;
    scan_row(0, 8'hFF, 16, 0, 1'b1, 1'b1);
    for (int r = 1; r < 7; r++) scan_row(r, 8'hFF, 8, 0, 1'b1, 1'b1);
    brightness = 3'd0;
    scan_row(7, 8'hFF, 8, 0, 1'b1, 1'b1);
    for (int r = 0; r < 5; r++) scan_row(r, 8'hFF, 2, 0, 1'b1, 1'b1);

    // abort during row 5
    chk("r5_row", row, 8'hDF);
    chk("r5_col0", col, 8'hFF);
    tick(); chk("r5_col1", col, 8'hFF);
    tick(); chk("r5_col2", col, 8'h00);
    enable = 1'b0;
    tick();
    chk("abort_row", row, 8'hFF);
    chk("abort_col", col, 8'h00);
    chk("abort_idx", row_idx, 3'd0);
    chk("abort_done", frame_done, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (frame_done || row != 8'hFF || col != 8'h00) seen = 1'b1;
    end
    chk("abort_dark", seen, 1'b0);

    // re-enable: row 0 after two blank cycles
    brightness = 3'd7;
    enable = 1'b1;
    tick(); chk("re_row_e0", row, 8'hFF);
    tick(); chk("re_row_e1", row, 8'hFF);
    tick(); chk("re_row_e2", row, 8'hFF);
    tick();
    scan_row(0, 8'hFF, 16, 0, 1'b1, 1'b1);
    scan_row(1, 8'hFF, 16, 0, 1'b1, 1'b1);

    // reset mid-DRIVE of row 2
    tick(); tick();
    chk("mid_row", row, 8'hFB);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_row", row, 8'hFF);
    chk("mid_rst_col", col, 8'h00);
    chk("mid_rst_ready", frame_ready, 1'b1);
    chk("mid_rst_done", frame_done, 1'b0);
    chk("mid_rst_idx", row_idx, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
